// File: rtl/sha256_mem_responder.sv
// Word memory behind the SHA-256 engine's master port, with a host LOAD/DUMP command port; engine has priority.
// Build option MEM_OOR_ERR_EN: accesses at or above DEPTH are suppressed and flagged in sticky oor_err.
module sha256_mem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 16,
  parameter int unsigned LENW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   mem_addr,
  input  logic            mem_we,
  input  logic [31:0]     mem_write_data,
  output logic [31:0]     mem_read_data,
  input  logic            engine_active,
  input  logic            host_cmd_valid,
  output logic            host_cmd_ready,
  input  logic            host_cmd_op,
  input  logic [AW-1:0]   host_cmd_addr,
  input  logic [LENW-1:0] host_cmd_len,
  input  logic [31:0]     host_wdata,
  input  logic            host_wvalid,
  output logic            host_wready,
  output logic [31:0]     host_rdata,
  output logic            host_rvalid,
  input  logic            host_rready,
  output logic            host_done,
  output logic [7:0]      wr_count,
  output logic            oor_err
);
  localparam int unsigned   IW      = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [31:0]   OOR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {IDLE, LOAD, DUMP_RD, DUMP_HOLD, DONE} state_t;
  state_t state_q, state_d;

  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   addr_q, haddr;
  logic [LENW-1:0] len_q, cnt_q, cnt_d;
  logic [7:0]      wr_count_q;
  logic            oor_q;
  logic [31:0]     mem_read_data_q, host_rdata_q;
  logic            cmd_acc, host_wr, dump_rd, last;
  logic            eng_oor, host_oor, oor_evt;
  logic            arr_we;
  logic [IW-1:0]   arr_idx;
  logic [31:0]     arr_wdata, arr_rd;

  assign haddr   = addr_q + AW'(cnt_q);
  assign cmd_acc = host_cmd_valid & host_cmd_ready;
  assign host_wr = host_wvalid & host_wready;
  assign dump_rd = (state_q == DUMP_RD) & !engine_active;
  assign last    = (cnt_q == len_q - 1'b1);

`ifdef MEM_OOR_ERR_EN
  assign eng_oor  = (mem_addr >= DEPTH_A);
  assign host_oor = (haddr >= DEPTH_A);
`else
  assign eng_oor  = 1'b0;
  assign host_oor = 1'b0;
  logic unused_hi;
  assign unused_hi = ^{mem_addr[AW-1:IW], haddr[AW-1:IW]};
`endif

  assign oor_evt = (engine_active & eng_oor) | ((host_wr | dump_rd) & host_oor);

  // Single array port: engine owns it whenever active, otherwise the host beat address drives it.
  always_comb begin
    arr_we    = 1'b0;
    arr_idx   = haddr[IW-1:0];
    arr_wdata = host_wdata;
    if (engine_active) begin
      arr_idx   = mem_addr[IW-1:0];
      arr_wdata = mem_write_data;
      arr_we    = mem_we & !eng_oor;
    end else if (host_wr) begin
      arr_we = !host_oor;
    end
  end

  assign arr_rd = mem_q[arr_idx];

  always_ff @(posedge clk) begin
    if (arr_we) mem_q[arr_idx] <= arr_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (cmd_acc) begin
        cnt_d = '0;
        if (host_cmd_len == '0) state_d = DONE;
        else                    state_d = host_cmd_op ? DUMP_RD : LOAD;
      end
      LOAD: if (host_wr) begin
        if (last) state_d = DONE;
        else      cnt_d   = cnt_q + 1'b1;
      end
      DUMP_RD: if (dump_rd) state_d = DUMP_HOLD;
      DUMP_HOLD: if (host_rready) begin
        if (last) state_d = DONE;
        else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = DUMP_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    host_cmd_ready = 1'b0;
    host_wready    = 1'b0;
    host_rvalid    = 1'b0;
    host_done      = 1'b0;
    unique case (state_q)
      IDLE:      host_cmd_ready = !engine_active & !reset;
      LOAD:      host_wready    = !engine_active;
      DUMP_HOLD: host_rvalid    = 1'b1;
      DONE:      host_done      = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q          <= '0;
      len_q           <= '0;
      wr_count_q      <= '0;
      oor_q           <= 1'b0;
      mem_read_data_q <= '0;
      host_rdata_q    <= '0;
    end else begin
      if (cmd_acc) begin
        addr_q     <= host_cmd_addr;
        len_q      <= host_cmd_len;
        wr_count_q <= '0;
        oor_q      <= 1'b0;
      end else begin
        if (engine_active && mem_we && wr_count_q != '1) wr_count_q <= wr_count_q + 8'd1;
        if (oor_evt) oor_q <= 1'b1;
      end
      if (engine_active && !mem_we) mem_read_data_q <= eng_oor ? OOR_DATA : arr_rd;
      if (dump_rd) host_rdata_q <= host_oor ? OOR_DATA : arr_rd;
    end
  end

  assign mem_read_data = mem_read_data_q;
  assign host_rdata    = host_rdata_q;
  assign wr_count      = wr_count_q;
  assign oor_err       = oor_q;
endmodule

// File: tb/tb_sha256_mem_responder.sv
// Directed self-checking bench for sha256_mem_responder; expectations adapt to MEM_OOR_ERR_EN.
module tb_sha256_mem_responder;
  logic        clk, reset;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_write_data, mem_read_data;
  logic        engine_active;
  logic        host_cmd_valid, host_cmd_ready, host_cmd_op;
  logic [15:0] host_cmd_addr;
  logic [7:0]  host_cmd_len;
  logic [31:0] host_wdata, host_rdata;
  logic        host_wvalid, host_wready, host_rvalid, host_rready, host_done;
  logic [7:0]  wr_count;
  logic        oor_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ld_data  [32];
  logic [31:0] exp_data [32];

  sha256_mem_responder #(.DEPTH(256), .AW(16), .LENW(8)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .engine_active(engine_active),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd_op(host_cmd_op), .host_cmd_addr(host_cmd_addr), .host_cmd_len(host_cmd_len),
    .host_wdata(host_wdata), .host_wvalid(host_wvalid), .host_wready(host_wready),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_rready(host_rready),
    .host_done(host_done), .wr_count(wr_count), .oor_err(oor_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic op, input logic [15:0] addr, input logic [7:0] len);
    host_cmd_valid = 1'b1;
    host_cmd_op    = op;
    host_cmd_addr  = addr;
    host_cmd_len   = len;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (host_cmd_ready) break;
      @(posedge clk); #1;
    end
    check("cmd_ready", {31'd0, host_cmd_ready}, 32'd1);
    @(posedge clk); #1;
    host_cmd_valid = 1'b0;
  endtask

  task automatic load_beats(input int len, input int stall_at, input int stall_n);
    int k = 0, cyc = 0, early_done = 0;
    host_wvalid = 1'b1;
    while (k < len && cyc < 200) begin
      engine_active = (cyc >= stall_at) && (cyc < stall_at + stall_n);
      mem_we     = 1'b0;
      mem_addr   = 16'h0080;
      host_wdata = ld_data[k];
      #1;
      check("load_wready", {31'd0, host_wready}, {31'd0, !engine_active});
      if (host_wready) k++;
      early_done += host_done;
      @(posedge clk); #1;
      cyc++;
    end
    host_wvalid   = 1'b0;
    engine_active = 1'b0;
    check("load_beats", k, len);
    check("load_early_done", early_done, 0);
    check("load_done", {31'd0, host_done}, 32'd1);
    @(posedge clk); #1;
    check("load_done_pulse", {31'd0, host_done}, 32'd0);
  endtask

  task automatic dump_beats(input int len);
    int k = 0, cyc = 0, early_done = 0;
    logic ph = 1'b0;
    while (k < len && cyc < 200) begin
      host_rready = 1'b0;
      if (host_rvalid) begin
        check("dump_data", host_rdata, exp_data[k]);
        host_rready = ph;
        if (ph) k++;
        ph = !ph;
      end
      early_done += host_done;
      @(posedge clk); #1;
      cyc++;
    end
    host_rready = 1'b0;
    check("dump_beats", k, len);
    check("dump_early_done", early_done, 0);
    check("dump_done", {31'd0, host_done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic eng_write(input logic [15:0] addr, input logic [31:0] data);
    engine_active = 1'b1; mem_we = 1'b1; mem_addr = addr; mem_write_data = data;
    @(posedge clk); #1;
    engine_active = 1'b0; mem_we = 1'b0;
  endtask

  task automatic eng_read(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    engine_active = 1'b1; mem_we = 1'b0; mem_addr = addr;
    @(posedge clk); #1;
    engine_active = 1'b0;
    check(tag, mem_read_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_addr = '0; mem_we = 1'b0; mem_write_data = '0; engine_active = 1'b0;
    host_cmd_valid = 1'b0; host_cmd_op = 1'b0; host_cmd_addr = '0; host_cmd_len = '0;
    host_wdata = '0; host_wvalid = 1'b0; host_rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", mem_read_data, 32'd0);
    check("rst_outs", {26'd0, host_cmd_ready, host_wready, host_rvalid, host_done, oor_err, 1'b0}, 32'd0);
    check("rst_wr_count", {24'd0, wr_count}, 32'd0);
    check("rst_host_rdata", host_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: LOAD 0..19 at address 0, wvalid held
    for (int i = 0; i < 20; i++) ld_data[i] = i;
    cmd(1'b0, 16'd0, 8'd20);
    load_beats(20, 1000, 0);
    check("t1_wr_count", {24'd0, wr_count}, 32'd0);

    // 2: engine read of address 5, then held while idle
    eng_read("t2_read5", 16'd5, 32'd5);
    mem_addr = 16'd7;
    repeat (3) @(posedge clk);
    #1;
    check("t2_hold", mem_read_data, 32'd5);

    // 3: engine writes, then DUMP with rready toggling
    for (int i = 0; i < 8; i++) eng_write(16'h0010 + 16'(i), 32'hA0 + 32'(i));
    check("t3_wr_count", {24'd0, wr_count}, 32'd8);
    for (int i = 0; i < 8; i++) exp_data[i] = 32'hA0 + 32'(i);
    cmd(1'b1, 16'h0010, 8'd8);
    check("t3_wr_count_clr", {24'd0, wr_count}, 32'd0);
    dump_beats(8);

    // 4: LOAD len 8 with a 3-cycle engine stall
    for (int i = 0; i < 8; i++) ld_data[i] = 32'h400 + 32'(i);
    cmd(1'b0, 16'h0040, 8'd8);
    load_beats(8, 3, 3);
    for (int i = 0; i < 8; i++) eng_read("t4_readback", 16'h0040 + 16'(i), 32'h400 + 32'(i));

    // 5: LOAD across the top of the array
    for (int i = 0; i < 4; i++) ld_data[i] = 32'h5000 + 32'(i);
    cmd(1'b0, 16'd254, 8'd4);
    load_beats(4, 1000, 0);
    eng_read("t5_254", 16'd254, 32'h5000);
    eng_read("t5_255", 16'd255, 32'h5001);
`ifdef MEM_OOR_ERR_EN
    check("t5_oor", {31'd0, oor_err}, 32'd1);
    eng_read("t5_0", 16'd0, 32'd0);
    eng_read("t5_1", 16'd1, 32'd1);
    eng_read("t5_256", 16'd256, 32'hDEADBEEF);
`else
    check("t5_oor", {31'd0, oor_err}, 32'd0);
    eng_read("t5_0", 16'd0, 32'h5002);
    eng_read("t5_1", 16'd1, 32'h5003);
`endif

    // 6: reset while a dump word is being held
    cmd(1'b1, 16'h0040, 8'd8);
    @(posedge clk); #1;
    check("t6_pre_rvalid", {31'd0, host_rvalid}, 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rvalid_drop", {31'd0, host_rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        seen += host_done;
        @(posedge clk); #1;
      end
      check("t6_no_done", seen, 0);
    end
    for (int i = 0; i < 8; i++) exp_data[i] = 32'h400 + 32'(i);
    cmd(1'b1, 16'h0040, 8'd8);
    dump_beats(8);

    // zero-length command completes directly
    cmd(1'b0, 16'd3, 8'd0);
    check("len0_done", {31'd0, host_done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
